// File: rtl/button_pulse_pkg.sv
// Shared types and constants for the button pulse generator.
// Holds the debounce FSM state encoding and the UP_DOWN reset value.
package button_pulse_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'b00,
        PRESS_WAIT   = 2'b01,
        HELD         = 2'b10,
        RELEASE_WAIT = 2'b11
    } deb_state_t;

    localparam logic UP_DOWN_RST = 1'b1;

endpackage

// File: rtl/button_pulse_gen_debounce_fsm.sv
// Per-button 2-flop synchroniser plus tick-timed debounce FSM.
// AUTOREPEAT_EN adds a 'held' output exposing the HELD state.
module debounce_fsm
    import button_pulse_pkg::*;
#(
    parameter int DEB_SAMPLES = 10
) (
    input  logic CLK,
    input  logic RST,
    input  logic tick,
    input  logic raw,
    output logic level,
    output logic press_pulse
`ifdef AUTOREPEAT_EN
    ,
    output logic held
`endif
);

    localparam int CW = $clog2(DEB_SAMPLES + 1);
    localparam logic [CW-1:0] CNT_DONE = CW'(DEB_SAMPLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic          r_sync1;
    logic          r_sync2;
    deb_state_t    r_state;
    deb_state_t    w_state_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic [CW-1:0] w_cnt_inc;
    logic          w_pulse;

    // Bring the asynchronous button into the CLK domain.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
        end
    end

    // State and sample-counter registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    assign w_cnt_inc = r_cnt + CNT_ONE;

    // Next state: only tick cycles count samples or move the FSM.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_pulse      = 1'b0;
        if (tick) begin
            unique case (r_state)
                IDLE: begin
                    if (r_sync2) begin
                        if (CNT_DONE == CNT_ONE) begin
                            w_state_next = HELD;
                            w_cnt_next   = '0;
                            w_pulse      = 1'b1;
                        end else begin
                            w_state_next = PRESS_WAIT;
                            w_cnt_next   = CNT_ONE;
                        end
                    end
                end
                PRESS_WAIT: begin
                    if (!r_sync2) begin
                        w_state_next = IDLE;
                        w_cnt_next   = '0;
                    end else if (w_cnt_inc == CNT_DONE) begin
                        w_state_next = HELD;
                        w_cnt_next   = '0;
                        w_pulse      = 1'b1;
                    end else begin
                        w_cnt_next = w_cnt_inc;
                    end
                end
                HELD: begin
                    if (!r_sync2) begin
                        if (CNT_DONE == CNT_ONE) begin
                            w_state_next = IDLE;
                            w_cnt_next   = '0;
                        end else begin
                            w_state_next = RELEASE_WAIT;
                            w_cnt_next   = CNT_ONE;
                        end
                    end
                end
                RELEASE_WAIT: begin
                    if (r_sync2) begin
                        w_state_next = HELD;
                        w_cnt_next   = '0;
                    end else if (w_cnt_inc == CNT_DONE) begin
                        w_state_next = IDLE;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = w_cnt_inc;
                    end
                end
            endcase
        end
    end

    // Level of the state being entered, so a registered copy lines up with ENABLE.
    assign level = (w_state_next == HELD) || (w_state_next == RELEASE_WAIT);
    assign press_pulse = w_pulse;

`ifdef AUTOREPEAT_EN
    assign held = (r_state == HELD);
`endif

endmodule

// File: rtl/button_pulse_gen.sv
// Debounced STEP/DIR front end producing ENABLE pulses and UP_DOWN level.
// Define AUTOREPEAT_EN to add auto-repeat ENABLE pulses while STEP is held.
module button_pulse_gen
    import button_pulse_pkg::*;
#(
    parameter int TICK_DIV     = 50000,
    parameter int DEB_SAMPLES  = 10,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100
) (
    input  logic CLK,
    input  logic RST,
    input  logic BTN_STEP,
    input  logic BTN_DIR,
    output logic ENABLE,
    output logic UP_DOWN,
    output logic STEP_LEVEL
);

    if (TICK_DIV < 2) begin : g_bad_tick_div
        $error("TICK_DIV must be >= 2");
    end
    if (DEB_SAMPLES < 1) begin : g_bad_deb
        $error("DEB_SAMPLES must be >= 1");
    end
    if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_repeat
        $error("REPEAT_DELAY and REPEAT_RATE must be >= 1");
    end

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] r_presc;
    logic          w_tick;
    logic          w_step_level;
    logic          w_step_pulse;
    logic          w_dir_level_unused;
    logic          w_dir_pulse;
    logic          w_repeat_pulse;
    logic          r_enable;
    logic          r_up_down;
    logic          r_step_level;

    assign w_tick = (r_presc == PRESC_LAST);

    // Free-running sample prescaler, wraps after TICK_DIV cycles.
    always_ff @(posedge CLK) begin
        if (RST || w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

`ifdef AUTOREPEAT_EN
    logic w_step_held;
    logic w_dir_held_unused;
`endif

    debounce_fsm #(
        .DEB_SAMPLES(DEB_SAMPLES)
    ) u_step (
        .CLK        (CLK),
        .RST        (RST),
        .tick       (w_tick),
        .raw        (BTN_STEP),
        .level      (w_step_level),
        .press_pulse(w_step_pulse)
`ifdef AUTOREPEAT_EN
        ,
        .held       (w_step_held)
`endif
    );

    debounce_fsm #(
        .DEB_SAMPLES(DEB_SAMPLES)
    ) u_dir (
        .CLK        (CLK),
        .RST        (RST),
        .tick       (w_tick),
        .raw        (BTN_DIR),
        .level      (w_dir_level_unused),
        .press_pulse(w_dir_pulse)
`ifdef AUTOREPEAT_EN
        ,
        .held       (w_dir_held_unused)
`endif
    );

`ifdef AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY
                                                       : REPEAT_RATE;
    localparam int RW = $clog2(RMAX + 1);
    localparam logic [RW-1:0] REP_DELAY = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] REP_RATE  = RW'(REPEAT_RATE);

    logic [RW-1:0] r_rep_cnt;
    logic          r_rep_after;
    logic [RW-1:0] w_rep_inc;

    assign w_rep_inc = r_rep_cnt + RW'(1);

    // Extra pulse after the initial delay, then at the repeat rate.
    always_comb begin
        w_repeat_pulse = 1'b0;
        if (w_tick && w_step_held) begin
            w_repeat_pulse = r_rep_after ? (w_rep_inc == REP_RATE)
                                         : (w_rep_inc == REP_DELAY);
        end
    end

    // Repeat counter runs only in HELD and restarts on every entry.
    always_ff @(posedge CLK) begin
        if (RST || !w_step_held) begin
            r_rep_cnt   <= '0;
            r_rep_after <= 1'b0;
        end else if (w_tick) begin
            if (w_repeat_pulse) begin
                r_rep_cnt   <= '0;
                r_rep_after <= 1'b1;
            end else begin
                r_rep_cnt <= w_rep_inc;
            end
        end
    end
`else
    assign w_repeat_pulse = 1'b0;
`endif

    // Output registers; ENABLE and UP_DOWN update on the same edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_enable     <= 1'b0;
            r_up_down    <= UP_DOWN_RST;
            r_step_level <= 1'b0;
        end else begin
            r_enable     <= w_step_pulse | w_repeat_pulse;
            r_up_down    <= w_dir_pulse ? ~r_up_down : r_up_down;
            r_step_level <= w_step_level;
        end
    end

    assign ENABLE     = r_enable;
    assign UP_DOWN    = r_up_down;
    assign STEP_LEVEL = r_step_level;

endmodule

// File: tb/tb_button_pulse_gen.sv
// Directed testbench for button_pulse_gen (TICK_DIV=4, DEB_SAMPLES=3).
// Honours AUTOREPEAT_EN for the auto-repeat scenario.
module tb_button_pulse_gen;

    localparam int TICK_DIV     = 4;
    localparam int DEB_SAMPLES  = 3;
    localparam int REPEAT_DELAY = 5;
    localparam int REPEAT_RATE  = 2;
`ifdef AUTOREPEAT_EN
    localparam int HOLD_CLEAN   = 20;
`else
    localparam int HOLD_CLEAN   = 40;
`endif

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic BTN_STEP = 1'b0;
    logic BTN_DIR = 1'b0;
    logic ENABLE;
    logic UP_DOWN;
    logic STEP_LEVEL;

    int total = 0;
    int bad = 0;

    int cyc = 0;
    int pulses = 0;
    int wide = 0;
    int ud_toggles = 0;
    int last_rise = 0;
    int last_ud = 0;
    logic lvl_at_rise = 1'b0;
    logic prev_en = 1'b0;
    logic prev_ud = 1'b1;
    int rise_q[$];

    button_pulse_gen #(
        .TICK_DIV    (TICK_DIV),
        .DEB_SAMPLES (DEB_SAMPLES),
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE (REPEAT_RATE)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .BTN_STEP  (BTN_STEP),
        .BTN_DIR   (BTN_DIR),
        .ENABLE    (ENABLE),
        .UP_DOWN   (UP_DOWN),
        .STEP_LEVEL(STEP_LEVEL)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        cyc++;
        if (ENABLE === 1'b1 && prev_en !== 1'b1) begin
            pulses++;
            last_rise = cyc;
            lvl_at_rise = STEP_LEVEL;
            rise_q.push_back(cyc);
        end
        if (ENABLE === 1'b1 && prev_en === 1'b1) wide++;
        if (UP_DOWN !== prev_ud) begin
            ud_toggles++;
            last_ud = cyc;
        end
        prev_en = ENABLE;
        prev_ud = UP_DOWN;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge CLK);
            #1;
        end
    endtask

    task automatic test_reset();
        int e_en;
        int e_ud;
        int e_lv;
        RST = 1'b1;
        step(3);
        total++;
        if (ENABLE !== 1'b0) begin
            bad++;
            $display("FAIL reset_enable got=%b want=0", ENABLE);
        end
        total++;
        if (UP_DOWN !== 1'b1) begin
            bad++;
            $display("FAIL reset_up_down got=%b want=1", UP_DOWN);
        end
        total++;
        if (STEP_LEVEL !== 1'b0) begin
            bad++;
            $display("FAIL reset_step_level got=%b want=0", STEP_LEVEL);
        end
        RST = 1'b0;
        e_en = 0;
        e_ud = 0;
        e_lv = 0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (ENABLE !== 1'b0) e_en++;
            if (UP_DOWN !== 1'b1) e_ud++;
            if (STEP_LEVEL !== 1'b0) e_lv++;
        end
        total++;
        if (e_en !== 0) begin
            bad++;
            $display("FAIL idle_enable bad_cycles=%0d want=0", e_en);
        end
        total++;
        if (e_ud !== 0) begin
            bad++;
            $display("FAIL idle_up_down bad_cycles=%0d want=0", e_ud);
        end
        total++;
        if (e_lv !== 0) begin
            bad++;
            $display("FAIL idle_step_level bad_cycles=%0d want=0", e_lv);
        end
    endtask

    task automatic test_step_clean();
        int p0;
        int w0;
        int t0;
        int lat;
        p0 = pulses;
        w0 = wide;
        t0 = cyc;
        BTN_STEP = 1'b1;
        step(HOLD_CLEAN);
        lat = last_rise - t0;
        total++;
        if (pulses - p0 !== 1) begin
            bad++;
            $display("FAIL clean_count got=%0d want=1", pulses - p0);
        end
        total++;
        if (lat < 11 || lat > 19) begin
            bad++;
            $display("FAIL clean_latency got=%0d want=11..19", lat);
        end
        total++;
        if (lvl_at_rise !== 1'b1) begin
            bad++;
            $display("FAIL clean_level_at_pulse got=%b want=1", lvl_at_rise);
        end
        BTN_STEP = 1'b0;
        step(30);
        total++;
        if (wide - w0 !== 0) begin
            bad++;
            $display("FAIL clean_width wide_cycles=%0d want=0", wide - w0);
        end
        total++;
        if (STEP_LEVEL !== 1'b0) begin
            bad++;
            $display("FAIL clean_release_level got=%b want=0", STEP_LEVEL);
        end
        total++;
        if (pulses - p0 !== 1) begin
            bad++;
            $display("FAIL clean_release_pulse got=%0d want=1", pulses - p0);
        end
    endtask

    task automatic test_bounce();
        int p0;
        int t0;
        int lat;
        p0 = pulses;
        for (int i = 0; i < 6; i++) begin
            BTN_STEP = (i % 2 == 0);
            step(5);
        end
        total++;
        if (pulses - p0 !== 0) begin
            bad++;
            $display("FAIL bounce_no_pulse got=%0d want=0", pulses - p0);
        end
        t0 = cyc;
        BTN_STEP = 1'b1;
        step(HOLD_CLEAN);
        lat = last_rise - t0;
        total++;
        if (pulses - p0 !== 1) begin
            bad++;
            $display("FAIL bounce_held_count got=%0d want=1", pulses - p0);
        end
        total++;
        if (lat < 11 || lat > 19) begin
            bad++;
            $display("FAIL bounce_latency got=%0d want=11..19", lat);
        end
        BTN_STEP = 1'b0;
        step(30);
    endtask

    task automatic test_dir();
        int d0;
        int p0;
        d0 = ud_toggles;
        p0 = pulses;
        BTN_DIR = 1'b1;
        step(25);
        BTN_DIR = 1'b0;
        step(25);
        total++;
        if (UP_DOWN !== 1'b0) begin
            bad++;
            $display("FAIL dir_first got=%b want=0", UP_DOWN);
        end
        total++;
        if (ud_toggles - d0 !== 1) begin
            bad++;
            $display("FAIL dir_first_toggles got=%0d want=1", ud_toggles - d0);
        end
        BTN_DIR = 1'b1;
        step(25);
        BTN_DIR = 1'b0;
        step(25);
        total++;
        if (UP_DOWN !== 1'b1) begin
            bad++;
            $display("FAIL dir_second got=%b want=1", UP_DOWN);
        end
        total++;
        if (ud_toggles - d0 !== 2) begin
            bad++;
            $display("FAIL dir_second_toggles got=%0d want=2", ud_toggles - d0);
        end
        total++;
        if (pulses - p0 !== 0) begin
            bad++;
            $display("FAIL dir_no_enable got=%0d want=0", pulses - p0);
        end
    endtask

    task automatic test_same_cycle();
        int p0;
        int d0;
        int w0;
        p0 = pulses;
        d0 = ud_toggles;
        w0 = wide;
        BTN_STEP = 1'b1;
        BTN_DIR = 1'b1;
        step(HOLD_CLEAN);
        BTN_STEP = 1'b0;
        BTN_DIR = 1'b0;
        step(30);
        total++;
        if (pulses - p0 !== 1) begin
            bad++;
            $display("FAIL same_count got=%0d want=1", pulses - p0);
        end
        total++;
        if (ud_toggles - d0 !== 1) begin
            bad++;
            $display("FAIL same_toggles got=%0d want=1", ud_toggles - d0);
        end
        total++;
        if (last_rise !== last_ud) begin
            bad++;
            $display("FAIL same_edge enable_cyc=%0d want=%0d", last_rise, last_ud);
        end
        total++;
        if (UP_DOWN !== 1'b0) begin
            bad++;
            $display("FAIL same_dir got=%b want=0", UP_DOWN);
        end
        total++;
        if (wide - w0 !== 0) begin
            bad++;
            $display("FAIL same_width wide_cycles=%0d want=0", wide - w0);
        end
    endtask

    task automatic test_reset_mid_press();
        int p0;
        int k;
        int q0;
        int exp_n;
        p0 = pulses;
        BTN_STEP = 1'b1;
        step(10);
        k = cyc;
        RST = 1'b1;
        step(1);
        total++;
        if (ENABLE !== 1'b0 || UP_DOWN !== 1'b1) begin
            bad++;
            $display("FAIL midrst_outputs got=%b%b want=01", ENABLE, UP_DOWN);
        end
        RST = 1'b0;
        total++;
        if (pulses - p0 !== 0) begin
            bad++;
            $display("FAIL midrst_old_progress got=%0d want=0", pulses - p0);
        end
        q0 = rise_q.size();
        step(13);
        total++;
        if (pulses - p0 !== 1 || last_rise - k !== 13) begin
            bad++;
            $display("FAIL midrst_requal count=%0d at=%0d want 1 at 13",
                     pulses - p0, last_rise - k);
        end
        step(77);
`ifdef AUTOREPEAT_EN
        exp_n = 9;
`else
        exp_n = 1;
`endif
        total++;
        if (pulses - p0 !== exp_n) begin
            bad++;
            $display("FAIL midrst_hold_count got=%0d want=%0d", pulses - p0, exp_n);
        end
`ifdef AUTOREPEAT_EN
        total++;
        if (rise_q.size() < q0 + 3 ||
            rise_q[q0+1] - rise_q[q0] !== 20 ||
            rise_q[q0+2] - rise_q[q0+1] !== 8) begin
            bad++;
            $display("FAIL repeat_spacing got=%0d pulses want gaps 20,8",
                     rise_q.size() - q0);
        end
`endif
        BTN_STEP = 1'b0;
        step(30);
    endtask

    initial begin
        test_reset();
        test_step_clean();
        test_bounce();
        test_dir();
        test_same_cycle();
        test_reset_mid_press();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
